halfadder_checker: RTL

//   Synthesizable self-test engine for the halfadder cell: drives x/y through all four

---
 rtl/halfadder_checker.sv | 108 ++++++++++
 1 files changed

// File: rtl/halfadder_checker.sv
// Self-test engine for a halfadder cell: steps x/y through 00,01,10,11, compares S/C
// against x^y and x&y, and reports pass/fail, a saturating error count and the first failing vector.
module halfadder_checker #(
  parameter int HOLD = 2,
  parameter int ERRW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_s,
  input  logic            dut_c,
  output logic            dut_x,
  output logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic [1:0]      fail_vec
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      r_vec;
  logic [HW-1:0]   r_hold;
  logic            r_first;

  logic            w_last;
  logic            w_exp_s;
  logic            w_exp_c;
  logic            w_mismatch;
  logic [ERRW-1:0] w_err_next;

  // Expected response comes from the vector register, not from the driven pins.
  always_comb begin
    w_last     = (r_hold == HOLD_LAST);
    w_exp_s    = r_vec[1] ^ r_vec[0];
    w_exp_c    = r_vec[1] & r_vec[0];
    w_mismatch = (dut_s != w_exp_s) || (dut_c != w_exp_c);
    w_err_next = err_count;
    if (w_mismatch && !(&err_count))
      w_err_next = err_count + ERRW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_vec     <= '0;
      r_hold    <= '0;
      r_first   <= 1'b0;
      dut_x     <= 1'b0;
      dut_y     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state   <= ST_DRIVE;
            r_vec     <= '0;
            r_hold    <= '0;
            r_first   <= 1'b0;
            dut_x     <= 1'b0;
            dut_y     <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
          end
        end
        ST_DRIVE: begin
          if (!w_last) begin
            r_hold <= r_hold + HW'(1);
          end else begin
            err_count <= w_err_next;
            if (w_mismatch && !r_first) begin
              fail_vec <= r_vec;
              r_first  <= 1'b1;
            end
            if (r_vec != 2'd3) begin
              r_vec          <= r_vec + 2'd1;
              r_hold         <= '0;
              {dut_x, dut_y} <= r_vec + 2'd1;
            end else begin
              r_state <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (w_err_next == '0);
              dut_x   <= 1'b0;
              dut_y   <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
